// File: rtl/serial_defs_pkg.sv
// Shared serial-path definitions: sequencer state encoding and common widths.
// Reused by the transmit arbiter and the receptor/controller sequencers.
package serial_defs;

    localparam int BYTE_W  = 8;
    localparam int GRANT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last',
// wrapping at N_REQ, so the last winner has the lowest priority.
module rr_pick
    import serial_defs::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] last,
    output logic [GRANT_W-1:0] idx,
    output logic               valid
);

    // Walk offsets 1..N_REQ from the last winner; the first hit wins.
    always_comb begin
        int pos;
        pos   = 0;
        idx   = '0;
        valid = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            pos = (int'(last) + off) % N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (!valid && (i == pos) && req[i]) begin
                    valid = 1'b1;
                    idx   = GRANT_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Grants a requester, latches its byte, pulses tx_start, waits for tx_done and
// then holds off GAP_CYCLES clocks before the next grant.
// Optional: define TX_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYC
// clocks without tx_done (err_timeout pulses, then the normal gap follows).
module uart_tx_arbiter
    import serial_defs::*;
#(
    parameter int N_REQ       = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0][BYTE_W-1:0]  req_data,
    output logic [N_REQ-1:0]              ack,
    output logic                          tx_start,
    output logic [BYTE_W-1:0]             tx_data,
    input  logic                          tx_done,
    output logic                          busy,
    output logic [GRANT_W-1:0]            grant_id,
    output logic                          err_timeout
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Where WAIT goes once the byte is finished (or abandoned).
    localparam arb_state_t AFTER_WAIT = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    arb_state_t          state, state_d;
    logic [N_REQ-1:0]    ack_d;
    logic                tx_start_d;
    logic [BYTE_W-1:0]   tx_data_d;
    logic [GRANT_W-1:0]  grant_d;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
    logic                pick_valid;
    logic [GRANT_W-1:0]  pick_idx;

`ifdef TX_ARB_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WCNT_W-1:0]   wait_cnt, wait_cnt_d;
    logic                err_d, err_q;
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign busy = (state != ST_IDLE);

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req),
        .last  (grant_id),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_d;
    end

    // Next state and next values of the registered outputs and counters.
    always_comb begin
        state_d    = state;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data;
        grant_d    = grant_id;
        gap_cnt_d  = gap_cnt;
`ifdef TX_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt;
        err_d      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                gap_cnt_d = '0;
                if (pick_valid) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick_idx == GRANT_W'(i)) begin
                            ack_d[i]  = 1'b1;
                            tx_data_d = req_data[i];
                        end
                    end
                    grant_d = pick_idx;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_start_d = 1'b1;
                state_d    = ST_WAIT;
`ifdef TX_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (tx_done) begin
                    state_d   = AFTER_WAIT;
                    gap_cnt_d = '0;
                end
`ifdef TX_ARB_TIMEOUT_EN
                else if (wait_cnt == WCNT_W'(TIMEOUT_CYC - 1)) begin
                    // Transmitter never answered: give up on this byte, no re-ack.
                    err_d     = 1'b1;
                    state_d   = AFTER_WAIT;
                    gap_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output registers and counters; reset drops any in-flight byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= GRANT_W'(N_REQ - 1);
            gap_cnt  <= '0;
`ifdef TX_ARB_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            ack      <= ack_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
            grant_id <= grant_d;
            gap_cnt  <= gap_cnt_d;
`ifdef TX_ARB_TIMEOUT_EN
            wait_cnt <= wait_cnt_d;
            err_q    <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: main instance (GAP_CYCLES=16,
// TIMEOUT_CYC=50) plus a GAP_CYCLES=0 instance; grants checked via a scoreboard.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic           tx_done;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           busy;
    logic [2:0]     grant_id;
    logic           err_timeout;

    logic [N-1:0]   g_req;
    logic [8*N-1:0] g_req_data;
    logic           g_tx_done;
    logic [N-1:0]   g_ack;
    logic           g_tx_start;
    logic [7:0]     g_tx_data;
    logic           g_busy;
    logic [2:0]     g_grant_id;
    logic           g_err_timeout;

    uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(16), .TIMEOUT_CYC(50)) u_dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .busy(busy),
        .grant_id(grant_id), .err_timeout(err_timeout)
    );

    uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(0), .TIMEOUT_CYC(50)) u_g0 (
        .clk(clk), .reset(reset), .req(g_req), .req_data(g_req_data), .ack(g_ack),
        .tx_start(g_tx_start), .tx_data(g_tx_data), .tx_done(g_tx_done), .busy(g_busy),
        .grant_id(g_grant_id), .err_timeout(g_err_timeout)
    );

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 400) begin
            tick();
            cnt++;
        end
    endtask

    task automatic pop_exp(output exp_t e);
        e = '{id: 3'd7, data: 8'h00};
        if (sb.size() > 0) e = sb.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (grant_id !== 3'd3) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 3", grant_id); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    endtask

    task automatic test_single();
        exp_t e;
        int   cnt;
        reset = 1'b1;
        tick();
        req = 4'b0001;
        req_data[7:0] = 8'h41;
        sb.push_back('{id: 3'd0, data: 8'h41});
        tick();
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", ack); end
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_early_start: got %b want 0", tx_start); end
        req = 4'b0000;
        tick();
        pop_exp(e);
        n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", tx_start); end
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_drop: got %b want 0000", ack); end
        n_checks++; if (tx_data !== e.data) begin n_fail++; $display("FAIL single_data: got %h want %h", tx_data, e.data); end
        n_checks++; if (grant_id !== e.id) begin n_fail++; $display("FAIL single_grant: got %0d want %0d", grant_id, e.id); end
        tick();
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_width: got %b want 0", tx_start); end
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_idle(cnt);
        n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL single_gap_len: got %0d want 16", cnt); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit   ok;
        int   last_cyc, cnt;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        sb.push_back('{id: 3'd0, data: 8'hA0});
        sb.push_back('{id: 3'd1, data: 8'hB1});
        sb.push_back('{id: 3'd2, data: 8'hC2});
        sb.push_back('{id: 3'd3, data: 8'hD3});
        sb.push_back('{id: 3'd0, data: 8'hA0});
        req = 4'b1111;
        last_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            wait_start(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_start_timeout: grant %0d got none want tx_start", k); end
            pop_exp(e);
            n_checks++; if (grant_id !== e.id) begin n_fail++; $display("FAIL rr_order: grant %0d got id %0d want %0d", k, grant_id, e.id); end
            n_checks++; if (tx_data !== e.data) begin n_fail++; $display("FAIL rr_data: grant %0d got %h want %h", k, tx_data, e.data); end
            if (k > 0) begin
                n_checks++; if (cyc - last_cyc != 119) begin n_fail++; $display("FAIL rr_spacing: got %0d want 119", cyc - last_cyc); end
            end
            last_cyc = cyc;
            if (k == 4) req = 4'b0000;
            repeat (100) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        wait_idle(cnt);
    endtask

    task automatic test_dropped_req();
        exp_t e;
        bit   ok, bad;
        int   cnt;
        req = 4'b0001;
        req_data[7:0] = 8'h55;
        sb.push_back('{id: 3'd0, data: 8'h55});
        tick();
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL drop_ack0: got %b want 0001", ack); end
        req = 4'b0000;
        wait_start(ok);
        pop_exp(e);
        n_checks++; if (!ok || tx_data !== e.data) begin n_fail++; $display("FAIL drop_first: got %h want %h", tx_data, e.data); end
        tick();
        req = 4'b0100;
        req_data[23:16] = 8'hAA;
        tick();
        req = 4'b0000;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack !== 4'b0000 || tx_data !== 8'h55) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL drop_wait_hold: got ack %b data %h want 0000 55", ack, tx_data); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_idle(cnt);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack !== 4'b0000 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL drop_never_acked: got ack %b busy %b want 0000 0", ack, busy); end
        n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL drop_grant: got %0d want 0", grant_id); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        int   cnt;
        req = 4'b0001;
        req_data[7:0] = 8'h66;
        tick();
        req = 4'b0000;
        wait_start(ok);
        repeat (5) tick();
        reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || ack !== 4'b0000 || tx_start !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got busy %b ack %b start %b want 0 0000 0", busy, ack, tx_start); end
        n_checks++; if (tx_data !== 8'h00 || grant_id !== 3'd3) begin n_fail++; $display("FAIL midrst_data: got %h id %0d want 00 3", tx_data, grant_id); end
        tick();
        reset = 1'b1;
        req = 4'b0010;
        req_data[15:8] = 8'h31;
        sb.push_back('{id: 3'd1, data: 8'h31});
        tick();
        n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL midrst_ack1: got %b want 0010", ack); end
        req = 4'b0000;
        wait_start(ok);
        pop_exp(e);
        n_checks++; if (!ok || grant_id !== e.id || tx_data !== e.data) begin n_fail++; $display("FAIL midrst_grant1: got %0d/%h want %0d/%h", grant_id, tx_data, e.id, e.data); end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_idle(cnt);
    endtask

    task automatic test_gap0();
        bit ok;
        g_req = 4'b0001;
        g_req_data[7:0] = 8'h11;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (g_tx_start) ok = 1'b1;
        end
        n_checks++; if (!ok || g_tx_data !== 8'h11) begin n_fail++; $display("FAIL gap0_first: got %h want 11", g_tx_data); end
        repeat (3) tick();
        g_tx_done = 1'b1;
        tick();
        g_tx_done = 1'b0;
        n_checks++; if (g_busy !== 1'b0 || g_ack !== 4'b0000) begin n_fail++; $display("FAIL gap0_idle: got busy %b ack %b want 0 0000", g_busy, g_ack); end
        tick();
        n_checks++; if (g_ack !== 4'b0001) begin n_fail++; $display("FAIL gap0_reack: got %b want 0001", g_ack); end
        g_req = 4'b0000;
        tick();
        n_checks++; if (g_tx_start !== 1'b1 || g_tx_data !== 8'h11) begin n_fail++; $display("FAIL gap0_second: got %b/%h want 1/11", g_tx_start, g_tx_data); end
        repeat (2) tick();
        g_tx_done = 1'b1;
        tick();
        g_tx_done = 1'b0;
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   ok, bad;
        int   cnt;
        req = 4'b1000;
        req_data[31:24] = 8'h77;
        sb.push_back('{id: 3'd3, data: 8'h77});
        tick();
        n_checks++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL to_ack3: got %b want 1000", ack); end
        req = 4'b0000;
        wait_start(ok);
        pop_exp(e);
        n_checks++; if (!ok || grant_id !== e.id || tx_data !== e.data) begin n_fail++; $display("FAIL to_grant3: got %0d/%h want %0d/%h", grant_id, tx_data, e.id, e.data); end
`ifdef TX_ARB_TIMEOUT_EN
        bad = 1'b0;
        for (int i = 1; i < 50; i++) begin
            tick();
            if (err_timeout !== 1'b0 || ack !== 4'b0000) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL to_early: got early err/ack want none before 50"); end
        tick();
        n_checks++; if (err_timeout !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got err %b busy %b want 1 1", err_timeout, busy); end
        tick();
        n_checks++; if (err_timeout !== 1'b0 || ack !== 4'b0000) begin n_fail++; $display("FAIL to_width: got err %b ack %b want 0 0000", err_timeout, ack); end
        wait_idle(cnt);
        n_checks++; if (cnt != 15) begin n_fail++; $display("FAIL to_gap: got %0d want 15", cnt); end
`else
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (busy !== 1'b1 || err_timeout !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL to_hold: got busy %b err %b want 1 0", busy, err_timeout); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_idle(cnt);
        n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL to_gap: got %0d want 16", cnt); end
`endif
    endtask

    initial begin
        req        = '0;
        req_data   = '0;
        tx_done    = 1'b0;
        g_req      = '0;
        g_req_data = '0;
        g_tx_done  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_dropped_req();
        test_reset_mid();
        test_gap0();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want finish within 1ms");
        $fatal(1, "watchdog");
    end

endmodule
